// File: rtl/decoder_n_seq.sv
// decoder_n_seq: mode-driven one-hot decoder with direct select, continuous scan and single sweep
module decoder_n_seq #(
  parameter int N = 4,
  parameter int DWELL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [N-1:0]         in_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [(1<<N)-1:0]    out_dec,
  output logic                 out_valid,
  output logic [N-1:0]         index,
  output logic                 done
);
  localparam int W = 1 << N;
  typedef enum logic [2:0] {IDLE, DIRECT, SCAN, SWEEP, DONE} state_t;
  state_t state, ns, target;
  logic [N-1:0] ni;
  logic [DWELL_W-1:0] cnt, nc;
  logic got, ng, nd, adv, stay, ov;
  assign in_ready = enable && state == DIRECT;
  // got remembers whether DIRECT has seen a transfer since entry
  always_comb begin
    target = mode == 2'b00 ? DIRECT : mode == 2'b01 ? SCAN : mode == 2'b10 ? SWEEP : IDLE;
    stay = state == target || (state == DONE && mode == 2'b10);
    adv = cnt >= dwell;
    ns = state;
    ni = index;
    nc = cnt;
    ng = got;
    nd = 1'b0;
    if (!stay) begin
      ns = target;
      ni = '0;
      nc = '0;
      ng = 1'b0;
    end else if (state == DIRECT && in_valid) begin
      ni = in_n;
      ng = 1'b1;
    end else if (state == SCAN || state == SWEEP) begin
      nc = adv ? '0 : cnt + 1'b1;
      ni = adv ? index + 1'b1 : index;
      if (state == SWEEP && adv && index == '1) begin
        ns = DONE;
        ni = '0;
        nd = 1'b1;
      end
    end
    ov = ns == SCAN || ns == SWEEP || (ns == DIRECT && ng);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      index <= '0;
      cnt <= '0;
      got <= 1'b0;
      out_dec <= '0;
      out_valid <= 1'b0;
      done <= 1'b0;
    end else if (!enable) begin
      out_dec <= '0;
      out_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= ns;
      index <= ni;
      cnt <= nc;
      got <= ng;
      out_valid <= ov;
      out_dec <= ov ? {{(W-1){1'b0}}, 1'b1} << ni : '0;
      done <= nd;
    end
  end
endmodule

// File: tb/tb_decoder_n_seq.sv
// tb_decoder_n_seq: directed scenario tasks for decoder_n_seq with N=4, DWELL_W=4
module tb_decoder_n_seq;
  logic clk = 1'b0;
  logic rst = 1'b0, enable = 1'b0, in_valid = 1'b0;
  logic [1:0] mode = 2'b11;
  logic [3:0] in_n = '0, dwell = '0;
  logic in_ready, out_valid, done;
  logic [15:0] out_dec;
  logic [3:0] index;
  int cmp = 0, bad = 0;

  decoder_n_seq #(.N(4), .DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .in_n(in_n),
    .in_valid(in_valid), .in_ready(in_ready), .dwell(dwell),
    .out_dec(out_dec), .out_valid(out_valid), .index(index), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b1;
    in_valid = 1'b0;
    mode = 2'b11;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    mode = 2'b01;
    step();
    cmp++;
    if ({out_dec, out_valid, index, done, in_ready} !== 23'd0) begin
      bad++;
      $display("FAIL reset: outputs=%h required 0", {out_dec, out_valid, index, done, in_ready});
    end
    rst = 1'b0;
    step();
    cmp++;
    if (out_dec !== 16'h0001 || out_valid !== 1'b1 || index !== 4'd0) begin
      bad++;
      $display("FAIL reset_exit_scan: out_dec=%h valid=%b index=%0d required 0001/1/0", out_dec, out_valid, index);
    end
  endtask

  task automatic test_direct();
    do_reset();
    mode = 2'b00;
    step();
    cmp++;
    if (out_valid !== 1'b0 || out_dec !== 16'h0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL direct_entry: valid=%b out_dec=%h ready=%b required 0/0000/1", out_valid, out_dec, in_ready);
    end
    in_n = 4'b1010;
    in_valid = 1'b1;
    step();
    cmp++;
    if (out_dec !== 16'h0400 || index !== 4'd10 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL direct_xfer: out_dec=%h index=%0d valid=%b required 0400/10/1", out_dec, index, out_valid);
    end
    in_valid = 1'b0;
    in_n = 4'd3;
    step();
    step();
    cmp++;
    if (out_dec !== 16'h0400 || index !== 4'd10 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL direct_hold: out_dec=%h index=%0d valid=%b required 0400/10/1", out_dec, index, out_valid);
    end
  endtask

  task automatic test_direct_disabled();
    enable = 1'b0;
    in_n = 4'b1011;
    in_valid = 1'b1;
    #1;
    cmp++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL direct_dis_ready: in_ready=%b required 0", in_ready);
    end
    step();
    cmp++;
    if (out_dec !== 16'h0 || out_valid !== 1'b0 || index !== 4'd10) begin
      bad++;
      $display("FAIL direct_dis_out: out_dec=%h valid=%b index=%0d required 0000/0/10", out_dec, out_valid, index);
    end
    in_valid = 1'b0;
    enable = 1'b1;
    step();
    cmp++;
    if (out_dec !== 16'h0400 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL direct_resume: out_dec=%h valid=%b required 0400/1", out_dec, out_valid);
    end
  endtask

  task automatic test_scan();
    do_reset();
    mode = 2'b01;
    dwell = 4'd1;
    step();
    for (int k = 0; k <= 33; k++) begin
      if (k > 0) step();
      cmp++;
      if (index !== 4'((k / 2) % 16) || out_dec !== (16'h0001 << ((k / 2) % 16)) || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL scan_k%0d: index=%0d out_dec=%h valid=%b required %0d", k, index, out_dec, out_valid, (k / 2) % 16);
      end
    end
  endtask

  task automatic test_sweep();
    do_reset();
    mode = 2'b10;
    dwell = 4'd0;
    step();
    for (int k = 0; k < 16; k++) begin
      if (k > 0) step();
      cmp++;
      if (index !== 4'(k) || out_dec !== (16'h0001 << k) || out_valid !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL sweep_k%0d: index=%0d out_dec=%h valid=%b done=%b", k, index, out_dec, out_valid, done);
      end
    end
    step();
    cmp++;
    if (out_dec !== 16'h0 || out_valid !== 1'b0 || done !== 1'b1 || index !== 4'd0) begin
      bad++;
      $display("FAIL sweep_done: out_dec=%h valid=%b done=%b index=%0d required 0000/0/1/0", out_dec, out_valid, done, index);
    end
    step();
    cmp++;
    if (out_dec !== 16'h0 || out_valid !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL sweep_done_hold1: out_dec=%h valid=%b done=%b required 0000/0/0", out_dec, out_valid, done);
    end
    step();
    cmp++;
    if (out_dec !== 16'h0 || done !== 1'b0) begin
      bad++;
      $display("FAIL sweep_done_hold2: out_dec=%h done=%b required 0000/0", out_dec, done);
    end
    mode = 2'b01;
    step();
    cmp++;
    if (out_dec !== 16'h0001 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL sweep_leave: out_dec=%h valid=%b required 0001/1", out_dec, out_valid);
    end
  endtask

  task automatic test_enable();
    do_reset();
    mode = 2'b01;
    dwell = 4'd3;
    step();
    repeat (20) step();
    cmp++;
    if (index !== 4'd5 || out_dec !== 16'h0020) begin
      bad++;
      $display("FAIL enable_pre: index=%0d out_dec=%h required 5/0020", index, out_dec);
    end
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      cmp++;
      if (out_dec !== 16'h0 || out_valid !== 1'b0 || index !== 4'd5) begin
        bad++;
        $display("FAIL enable_off_%0d: out_dec=%h valid=%b index=%0d required 0000/0/5", k, out_dec, out_valid, index);
      end
    end
    enable = 1'b1;
    step();
    cmp++;
    if (out_dec !== 16'h0020 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL enable_resume: out_dec=%h valid=%b required 0020/1", out_dec, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 2'b10;
    dwell = 4'd0;
    step();
    repeat (9) step();
    cmp++;
    if (index !== 4'd9) begin
      bad++;
      $display("FAIL mid_pre: index=%0d required 9", index);
    end
    rst = 1'b1;
    step();
    cmp++;
    if ({out_dec, out_valid, index, done, in_ready} !== 23'd0) begin
      bad++;
      $display("FAIL mid_reset: outputs=%h required 0", {out_dec, out_valid, index, done, in_ready});
    end
    rst = 1'b0;
    step();
    cmp++;
    if (index !== 4'd0 || out_dec !== 16'h0001 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_restart: index=%0d out_dec=%h valid=%b required 0/0001/1", index, out_dec, out_valid);
    end
  endtask

  task automatic test_dwell_and_mode();
    do_reset();
    mode = 2'b01;
    dwell = 4'd7;
    step();
    repeat (5) step();
    cmp++;
    if (index !== 4'd0) begin
      bad++;
      $display("FAIL dwell_pre: index=%0d required 0", index);
    end
    dwell = 4'd2;
    step();
    cmp++;
    if (index !== 4'd1 || out_dec !== 16'h0002) begin
      bad++;
      $display("FAIL dwell_lower: index=%0d out_dec=%h required 1/0002", index, out_dec);
    end
    mode = 2'b10;
    step();
    cmp++;
    if (index !== 4'd0 || out_dec !== 16'h0001 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL mode_switch: index=%0d out_dec=%h valid=%b required 0/0001/1", index, out_dec, out_valid);
    end
    mode = 2'b11;
    step();
    cmp++;
    if (out_dec !== 16'h0 || out_valid !== 1'b0 || index !== 4'd0) begin
      bad++;
      $display("FAIL mode_idle: out_dec=%h valid=%b index=%0d required 0000/0/0", out_dec, out_valid, index);
    end
    enable = 1'b0;
    mode = 2'b01;
    step();
    cmp++;
    if (out_dec !== 16'h0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mode_while_off: out_dec=%h valid=%b required 0000/0", out_dec, out_valid);
    end
    enable = 1'b1;
    step();
    cmp++;
    if (out_dec !== 16'h0001 || out_valid !== 1'b1 || index !== 4'd0) begin
      bad++;
      $display("FAIL mode_applied: out_dec=%h valid=%b index=%0d required 0001/1/0", out_dec, out_valid, index);
    end
  endtask

  initial begin
    step();
    test_reset();
    test_direct();
    test_direct_disabled();
    test_scan();
    test_sweep();
    test_enable();
    test_reset_mid();
    test_dwell_and_mode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/decoder_n_seq.md
DECODER_N_SEQ -- requirements
Module: decoder_n_seq

Interface
REQ-001 The block SHALL take parameter N, default 4, meaning select width; decoded output width is 2**N (N range 1..8).
REQ-002 The block SHALL take parameter DWELL_W, default 4, meaning width of the dwell-count field.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port enable  input  1  global enable; 0 freezes internal state and blanks outputs.
REQ-006 Port mode  input  2  00 DIRECT, 01 SCAN (continuous walk), 10 SWEEP (single walk), 11 reserved.
REQ-007 Port in_n  input  N  select code for DIRECT mode.
REQ-008 Port in_valid  input  1  in_n valid qualifier.
REQ-009 Port in_ready  output  1  block accepts in_n this cycle.
REQ-010 Port dwell  input  DWELL_W  scan/sweep: cycles per step minus one.
REQ-011 Port out_dec  output  2**N  registered one-hot decode, all-zero when inactive.
REQ-012 Port out_valid  output  1  out_dec carries a live one-hot value.
REQ-013 Port index  output  N  binary index of the asserted out_dec bit.
REQ-014 Port done  output  1  one-cycle pulse at SWEEP completion.

Function
REQ-015 The FSM SHALL have states IDLE, DIRECT, SCAN, SWEEP, DONE; state follows mode (00->DIRECT, 01->SCAN, 10->SWEEP, 11->IDLE), except SWEEP->DONE on completion.
REQ-016 A mode change SHALL take effect on the next clock edge, clearing index and dwell counter to 0; out_dec/out_valid during the transition cycle are those of the new state.
REQ-017 In DIRECT, in_ready SHALL be 1 when enable=1; in all other states or enable=0, in_ready SHALL be 0.
REQ-018 In DIRECT, a transfer (in_valid & in_ready) SHALL produce out_dec = 1<<in_n, index = in_n, out_valid = 1 on the following cycle (latency 1); without a transfer, outputs hold.
REQ-019 In DIRECT, out_valid SHALL stay 0 after entry until the first transfer.
REQ-020 In SCAN, out_dec SHALL be 1<<index with out_valid=1; the dwell counter increments each cycle and, when count >= dwell, clears and index advances by 1.
REQ-021 In SCAN, index SHALL wrap from 2**N-1 to 0 without a gap cycle.
REQ-022 dwell SHALL be sampled live each cycle; lowering dwell below the current count SHALL cause the advance on the next edge; dwell=0 advances every cycle.
REQ-023 In SWEEP, stepping SHALL match SCAN, but the advance from index 2**N-1 SHALL enter DONE instead of wrapping.
REQ-024 On entering DONE, done SHALL pulse 1 for exactly one cycle; in DONE, out_dec=0, out_valid=0, index=0; DONE persists until mode changes away from 10.
REQ-025 In IDLE, out_dec=0, out_valid=0, index=0, done=0.
REQ-026 With enable=0, out_dec=0, out_valid=0, done=0 on the next edge; state, index and dwell counter SHALL hold; on re-enable, outputs resume from held index on the next edge.
REQ-027 A mode change while enable=0 SHALL be applied on the first enabled edge.
REQ-028 out_dec SHALL never have more than one bit set.

Reset
REQ-029 With rst=1 at a clock edge: state=IDLE, out_dec=0, out_valid=0, index=0, done=0, in_ready=0, dwell counter=0, regardless of enable/mode.
REQ-030 rst SHALL take priority over all other inputs, including mid-sweep and mid-dwell; first post-reset edge follows REQ-015 from IDLE.

Verification (N=4, DWELL_W=4)
REQ-031 DIRECT, enable=1, in_n=4'b1010, in_valid=1 for one cycle -> next cycle out_dec=16'h0400, index=10, out_valid=1, held after in_valid drops.
REQ-032 SCAN, dwell=1 -> index 0,0,1,1,...,15,15,0 (wrap), out_dec=16'h0001 at index 0, 16'h8000 at 15.
REQ-033 SWEEP, dwell=0 -> index 0..15 on 16 consecutive cycles, then out_dec=0, out_valid=0, done=1 for one cycle, remains in DONE.
REQ-034 SCAN at index 5, enable=0 for 3 cycles -> out_dec=0, out_valid=0; enable=1 -> out_dec=16'h0020 resumes.
REQ-035 DIRECT with enable=0, in_n=4'b1011, in_valid=1 -> in_ready=0, no transfer, out_dec=0.
REQ-036 rst=1 mid-SWEEP at index 9 -> next cycle all outputs 0, state IDLE; SCAN dwell=7 lowered to 2 at count 5 -> index advances next edge.
